// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32I sequencer.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB.
// One shared memory port is used for both fetch and load/store traffic.
// Datapath enables are decoded from the state register (Moore outputs).
// IRWrite and DataWrite are also qualified by mem_ready.
// An illegal opcode or a memory timeout parks the core in HALT.
module core_seq_ctrl #(
   parameter int TIMEOUT = 16,   // max cycles a request may wait for ready (>= 2)
   parameter int RCW     = 32    // retired-instruction counter width
) (
   input  logic           clk,
   input  logic           reset,       // asynchronous, active-low
   input  logic [6:0]     Op,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           mem_we,
   output logic           mem_sel,
   output logic           IRWrite,
   output logic           DataWrite,
   output logic           PCWrite,
   output logic           RegWrite,
   output logic [2:0]     state,
   output logic           halted,
   output logic           illegal,
   output logic           bus_err,
   output logic [RCW-1:0] retire_cnt
);

   // Wait counter is wide enough to hold TIMEOUT-1 with a spare bit.
   localparam int WCW = $clog2(TIMEOUT) + 1;
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // Instruction classes; the encoding doubles as the index into OPC_TABLE.
   typedef enum logic [3:0] {
      C_LOAD   = 4'd0,
      C_STORE  = 4'd1,
      C_ALU_R  = 4'd2,
      C_ALU_I  = 4'd3,
      C_BRANCH = 4'd4,
      C_JAL    = 4'd5,
      C_JALR   = 4'd6,
      C_LUI    = 4'd7,
      C_AUIPC  = 4'd8
   } class_t;

   localparam int NUM_CLASSES = 9;

   // Opcode table, entry k (bits 7k+6:7k) belongs to class encoding k.
   localparam logic [NUM_CLASSES*7-1:0] OPC_TABLE = {
      7'b0010111,   // AUIPC
      7'b0110111,   // LUI
      7'b1100111,   // JALR
      7'b1101111,   // JAL
      7'b1100011,   // BRANCH
      7'b0010011,   // ALU_I
      7'b0110011,   // ALU_R
      7'b0100011,   // STORE
      7'b0000011    // LOAD
   };

   state_t           state_reg;
   class_t           class_reg;
   logic [WCW-1:0]   wait_cnt_reg;
   logic             illegal_reg;
   logic             bus_err_reg;
   logic [RCW-1:0]   retire_cnt_reg;

   logic [NUM_CLASSES-1:0] op_hit;
   logic                   op_legal;
   class_t                 op_class;
   logic                   wait_expired;
   logic                   class_is_mem;

   // One comparator per supported opcode.
   generate
      for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_opc
         assign op_hit[gi] = (Op == OPC_TABLE[gi*7 +: 7]);
      end
   endgenerate

   // Fold the one-hot opcode match into a class code; no hit means illegal.
   always_comb begin
      op_legal = |op_hit;
      op_class = C_ALU_R;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (op_hit[i]) begin
            op_class = class_t'(4'(i));
         end
      end
   end

   // A request has waited its last allowed cycle without ready.
   assign wait_expired = (wait_cnt_reg == WAIT_LIMIT) && !mem_ready;
   assign class_is_mem = (class_reg == C_LOAD) || (class_reg == C_STORE);

   // Sequencer: state, instruction class, wait counter, sticky causes, retire count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_BOOT;
         class_reg      <= C_ALU_R;
         wait_cnt_reg   <= '0;
         illegal_reg    <= 1'b0;
         bus_err_reg    <= 1'b0;
         retire_cnt_reg <= '0;
      end else begin
         case (state_reg)
            S_BOOT: begin
               state_reg    <= S_FETCH;
               wait_cnt_reg <= '0;
            end
            S_FETCH: begin
               if (mem_ready) begin
                  state_reg <= S_DECODE;
               end else if (wait_expired) begin
                  state_reg   <= S_HALT;
                  bus_err_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WCW'(1);
               end
            end
            S_DECODE: begin
               // Op is only looked at here; it may change freely elsewhere.
               if (op_legal) begin
                  class_reg <= op_class;
                  state_reg <= S_EXEC;
               end else begin
                  state_reg   <= S_HALT;
                  illegal_reg <= 1'b1;
               end
            end
            S_EXEC: begin
               if (class_is_mem) begin
                  state_reg    <= S_MEM;
                  wait_cnt_reg <= '0;
               end else begin
                  state_reg <= S_WB;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  state_reg <= S_WB;
               end else if (wait_expired) begin
                  state_reg   <= S_HALT;
                  bus_err_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WCW'(1);
               end
            end
            S_WB: begin
               retire_cnt_reg <= retire_cnt_reg + RCW'(1);
               state_reg      <= S_FETCH;
               wait_cnt_reg   <= '0;
            end
            S_HALT: begin
               state_reg <= S_HALT;
            end
            default: begin
               // Unused encoding: treat as corrupted control, stop the core.
               state_reg   <= S_HALT;
               illegal_reg <= 1'b1;
            end
         endcase
      end
   end

   // Moore decode of the datapath controls from the state register.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      IRWrite   = 1'b0;
      DataWrite = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      halted    = 1'b0;
      case (state_reg)
         S_FETCH: begin
            mem_req = 1'b1;
            IRWrite = mem_ready;
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_sel   = 1'b1;
            mem_we    = (class_reg == C_STORE);
            DataWrite = (class_reg == C_LOAD) && mem_ready;
         end
         S_WB: begin
            PCWrite  = 1'b1;
            RegWrite = (class_reg != C_STORE) && (class_reg != C_BRANCH);
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign state      = state_reg;
   assign illegal    = illegal_reg;
   assign bus_err    = bus_err_reg;
   assign retire_cnt = retire_cnt_reg;

endmodule
